// File: rtl/gt_rx_link_ctrl.sv
// GT RX lane sequencer: comma realign, elastic-buffer reset, IDLE-based link confirmation, payload gating.
// Latency: all outputs registered; a payload word appears 1 cycle after it is sampled in UP.
// Backpressure: none; data words are forwarded only while the lane is up, everything else is dropped.
// Optional feature: define GT_RX_LINK_CTRL_CC_MONITOR_EN to add the clock-correction warning timeout.
module gt_rx_link_ctrl #(
  parameter logic [15:0] g_IDLE          = 16'hbc95,
  parameter logic [1:0]  g_IDLE_K        = 2'b10,
  parameter int unsigned g_BLIND_PERIOD  = 10,
  parameter int unsigned g_GOOD_IDLE_CNT = 4,
  parameter int unsigned g_ALIGN_TIMEOUT = 1024,
  parameter int unsigned g_CC_TIMEOUT    = 193,
  parameter int unsigned g_RESET_CYCLES  = 8
) (
  input  logic        usrclk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [15:0] rx_data_i,
  input  logic [1:0]  rx_k_i,
  input  logic        rx_aligned_i,
  input  logic [2:0]  rx_bufstatus_i,
  output logic        rx_realign_o,
  output logic        rx_bufreset_o,
  output logic        link_up_o,
  output logic [15:0] rx_data_o,
  output logic        rx_data_valid_o,
  output logic [2:0]  state_o,
  output logic [15:0] err_cnt_o
);

  // State encodings are visible on state_o, so they are fixed values.
  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_ALIGN    = 3'd1;
  localparam logic [2:0] ST_BLIND    = 3'd2;
  localparam logic [2:0] ST_CHECK    = 3'd3;
  localparam logic [2:0] ST_UP       = 3'd4;
  localparam logic [2:0] ST_BUFRESET = 3'd5;

  // One shared per-state counter: ALIGN timeout, BLIND length, BUFRESET pulse
  // width, and in UP the run length of consecutive clock-correction warnings.
  // It is sized for the longest interval any of those may need.
  localparam int unsigned LP_MAX_A   = (g_ALIGN_TIMEOUT > g_BLIND_PERIOD) ? g_ALIGN_TIMEOUT : g_BLIND_PERIOD;
  localparam int unsigned LP_MAX_B   = (g_RESET_CYCLES > g_CC_TIMEOUT) ? g_RESET_CYCLES : g_CC_TIMEOUT;
  localparam int unsigned LP_CNT_MAX = (LP_MAX_A > LP_MAX_B) ? LP_MAX_A : LP_MAX_B;
  localparam int unsigned LP_CNT_W   = $clog2(LP_CNT_MAX + 1);
  localparam int unsigned LP_GOOD_W  = $clog2(g_GOOD_IDLE_CNT + 1);

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of an N-cycle interval is the one where the counter reads N-1.
  localparam logic [LP_CNT_W-1:0]  LP_ALIGN_LAST = LP_CNT_W'(g_ALIGN_TIMEOUT - 1);
  localparam logic [LP_CNT_W-1:0]  LP_BLIND_LAST = LP_CNT_W'(g_BLIND_PERIOD - 1);
  localparam logic [LP_CNT_W-1:0]  LP_RESET_LAST = LP_CNT_W'(g_RESET_CYCLES - 1);
  localparam logic [LP_GOOD_W-1:0] LP_GOOD_LAST  = LP_GOOD_W'(g_GOOD_IDLE_CNT - 1);

  logic [2:0]           r_state;
  logic [LP_CNT_W-1:0]  r_cnt;
  logic [LP_GOOD_W-1:0] r_good;
  logic [15:0]          r_err;
  logic                 r_realign;
  logic                 r_bufreset;
  logic                 r_link_up;
  logic [15:0]          r_data;
  logic                 r_data_vld;

  logic [2:0] w_state_nxt;
  logic       w_err;
  logic       w_entry;
  logic       w_idle_ok;
  logic       w_k_data;
  logic       w_comma_err;
  logic       w_buf_err;
  logic       w_cc_warn;
  logic       w_cc_tmo;
  logic       w_fwd;

  // Word classification. A word carrying the IDLE K pattern but the wrong
  // data is neither a good IDLE nor a comma error; it is simply not counted.
  assign w_idle_ok   = (rx_k_i == g_IDLE_K) && (rx_data_i == g_IDLE);
  assign w_k_data    = (rx_k_i == 2'b00);
  assign w_comma_err = !w_k_data && (rx_k_i != g_IDLE_K);
  assign w_buf_err   = (rx_bufstatus_i == 3'b110) || (rx_bufstatus_i == 3'b101);

`ifdef GT_RX_LINK_CTRL_CC_MONITOR_EN
  localparam logic [LP_CNT_W-1:0] LP_CC_LAST = LP_CNT_W'(g_CC_TIMEOUT - 1);

  // A warning fires on the g_CC_TIMEOUT-th consecutive warning cycle, i.e.
  // when this cycle warns and the run counter already holds g_CC_TIMEOUT-1.
  assign w_cc_warn = (rx_bufstatus_i == 3'b001) || (rx_bufstatus_i == 3'b010);
  assign w_cc_tmo  = w_cc_warn && (r_cnt == LP_CC_LAST);
`else
  // Clock-correction status codes are ignored; the UP counter never moves.
  assign w_cc_warn = 1'b0;
  assign w_cc_tmo  = 1'b0;
`endif

  // Next-state decode; branch order inside each state encodes the exit priority.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (enable_i) w_state_nxt = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (!enable_i) begin
          w_state_nxt = ST_OFF;
        end else if (rx_aligned_i) begin
          w_state_nxt = ST_BLIND;
        end else if (r_cnt == LP_ALIGN_LAST) begin
          w_state_nxt = ST_BUFRESET;
          w_err       = 1'b1;
        end
      end
      ST_BLIND: begin
        if (!enable_i) begin
          w_state_nxt = ST_OFF;
        end else if (!rx_aligned_i) begin
          w_state_nxt = ST_ALIGN;
          w_err       = 1'b1;
        end else if (r_cnt == LP_BLIND_LAST) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!enable_i) begin
          w_state_nxt = ST_OFF;
        end else if (!rx_aligned_i) begin
          w_state_nxt = ST_ALIGN;
          w_err       = 1'b1;
        end else if (w_buf_err) begin
          w_state_nxt = ST_BUFRESET;
          w_err       = 1'b1;
        end else if (w_comma_err) begin
          w_state_nxt = ST_ALIGN;
          w_err       = 1'b1;
        end else if (w_idle_ok && (r_good == LP_GOOD_LAST)) begin
          w_state_nxt = ST_UP;
        end
      end
      ST_UP: begin
        if (!enable_i) begin
          w_state_nxt = ST_OFF;
        end else if (!rx_aligned_i) begin
          w_state_nxt = ST_ALIGN;
          w_err       = 1'b1;
        end else if (w_buf_err) begin
          w_state_nxt = ST_BUFRESET;
          w_err       = 1'b1;
        end else if (w_comma_err) begin
          w_state_nxt = ST_ALIGN;
          w_err       = 1'b1;
        end else if (w_cc_tmo) begin
          w_state_nxt = ST_BUFRESET;
          w_err       = 1'b1;
        end
      end
      ST_BUFRESET: begin
        if (!enable_i) begin
          w_state_nxt = ST_OFF;
        end else if (r_cnt == LP_RESET_LAST) begin
          w_state_nxt = ST_ALIGN;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  assign w_entry = (w_state_nxt != r_state);

  // Forward only data words that do not also trigger an exit from UP.
  assign w_fwd = (r_state == ST_UP) && (w_state_nxt == ST_UP) && w_k_data;

  // State register and the control outputs, decoded from the state being entered.
  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_OFF;
      r_realign  <= 1'b0;
      r_bufreset <= 1'b0;
      r_link_up  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_realign  <= (w_state_nxt == ST_ALIGN);
      r_bufreset <= (w_state_nxt == ST_BUFRESET);
      r_link_up  <= (w_state_nxt == ST_UP);
    end
  end

  // Per-state counter: cleared on every state entry, otherwise advanced by the state that owns it.
  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_entry) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_ALIGN, ST_BLIND, ST_BUFRESET: r_cnt <= r_cnt + 1'b1;
        ST_UP:                           r_cnt <= w_cc_warn ? (r_cnt + 1'b1) : '0;
        default:                         r_cnt <= '0;
      endcase
    end
  end

  // Good-IDLE count in CHECK; non-IDLE data words leave it untouched.
  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_good <= '0;
    end else if (w_entry) begin
      r_good <= '0;
    end else if ((r_state == ST_CHECK) && w_idle_ok) begin
      r_good <= r_good + 1'b1;
    end
  end

  // Saturating error counter, one step per error-caused transition; cleared only by reset.
  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err <= '0;
    end else if (w_err && (r_err != 16'hFFFF)) begin
      r_err <= r_err + 16'd1;
    end
  end

  // Payload register: the strobe follows each forwarded word, the data holds otherwise.
  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data     <= '0;
      r_data_vld <= 1'b0;
    end else begin
      r_data_vld <= w_fwd;
      if (w_fwd) r_data <= rx_data_i;
    end
  end

  assign rx_realign_o    = r_realign;
  assign rx_bufreset_o   = r_bufreset;
  assign link_up_o       = r_link_up;
  assign rx_data_o       = r_data;
  assign rx_data_valid_o = r_data_vld;
  assign state_o         = r_state;
  assign err_cnt_o       = r_err;

endmodule
